regfile_nway: RTL and testbench
===============================

// Module: regfile_nway
// PURPOSE
//   Parametrised register bank and the sequential successor to the 8-way mux/dmux
//   gates. Write-address decode is the dmux-N-way function and each read port is a
//   mux-N-way of WIDTH bits. Storage is DEPTH = 2**ADDR_W words.
//   Adds a second read port, optional write-to-read bypass, and a timed clear-all
//   sweep. Serves as the Hack CPU scratch RAM / register file (RAM8/RAM64 role).
// PARAMETERS
//   WIDTH   16  data word width in bits
//   ADDR_W  3   address width; DEPTH = 2**ADDR_W (legal range 1..6)
//   BYPASS  0   1: a read port whose address equals an accepted write address
//               returns din in the same cycle; 0: returns the stored word
// PORTS
//   clk      in   1       single clock, rising-edge
//   rst_n    in   1       asynchronous, active-low reset
//   load     in   1       write request for this cycle
//   waddr    in   ADDR_W  write address
//   din      in   WIDTH   write data
//   raddr_a  in   ADDR_W  read port A address
//   dout_a   out  WIDTH   read port A data (combinational)
//   raddr_b  in   ADDR_W  read port B address
//   dout_b   out  WIDTH   read port B data (combinational)
//   clr      in   1       request a clear-all sweep (level sampled at clk edge)
//   busy     out  1       1 while the clear sweep runs
// BEHAVIOUR
//   - Reset (rst_n=0, async): all words <= 0, state IDLE, sweep counter <= 0.
//     busy = 0 and dout_a = dout_b = 0 until the first write.
//   - FSM states: IDLE, CLEAR.
//     IDLE -> CLEAR when clr=1 at a clk edge. CLEAR -> IDLE after the edge that
//     clears word DEPTH-1.
//   - Write (IDLE only): when load=1 at a clk edge, mem[waddr] <= din. Latency 1;
//     the new value is visible on dout from the next cycle.
//   - Clear sweep: the edge that sees clr=1 in IDLE sets cnt=0, busy=1 and writes
//     nothing. Each following CLEAR edge writes mem[cnt] <= 0 and increments cnt.
//     The edge with cnt=DEPTH-1 writes word DEPTH-1, returns to IDLE and drops busy.
//     busy is therefore high for exactly DEPTH cycles.
//   - While busy=1: load is dropped and never queued; clr is ignored with no
//     restart; reads return current contents, so uncleared words keep old data.
//   - Same edge in IDLE with both clr=1 and load=1: clr wins, the write is dropped.
//   - Reads are combinational: dout_x = mem[raddr_x]. Both ports may use the same
//     address. Any address is legal; there is no out-of-range case.
//   - BYPASS=1: if a write is accepted this cycle (IDLE, load=1, clr=0) and
//     raddr_x == waddr, then dout_x = din. No bypass while busy.
//   - cnt is ADDR_W bits wide. It wraps DEPTH-1 -> 0 only on the exit edge, which
//     is harmless.
//   - rst_n asserted mid-sweep: immediately IDLE, busy=0, all words 0.
// TESTING
//   1. Reset then idle: rst_n=0 for 2 cycles, then any raddr -> dout_a=dout_b=16'h0000
//      and busy=0.
//   2. Write and dual read: write 16'h1234 @3 and 16'hFEDC @5. Set raddr_a=3,
//      raddr_b=5 -> 16'h1234 / 16'hFEDC one cycle after each write. Also set
//      raddr_a=raddr_b=3 -> both read 16'h1234.
//   3. Bypass: BYPASS=1, load=1, waddr=2, din=16'hAAAA, raddr_a=2 -> dout_a=16'hAAAA
//      in the same cycle. With BYPASS=0 the same stimulus -> old value until the edge.
//   4. Clear sweep: fill all 8 words with 16'h5555, pulse clr -> busy high exactly
//      8 cycles. Word k reads 0 after sweep edge k+1, so words not yet swept still
//      read 16'h5555. load=1 @0 with 16'hFFFF during busy -> word 0 reads 0 afterwards.
//   5. Conflict: in IDLE, clr=1 and load=1 (waddr=7, din=16'h00FF) on the same
//      edge -> word 7 reads 0 after the sweep. clr re-pulsed mid-sweep -> busy
//      still ends after 8 cycles.
//   6. Reset mid-sweep plus width check: rst_n=0 at sweep cycle 4 -> busy=0 at
//      once and all words 0. Repeat tests 2 and 4 with WIDTH=8, ADDR_W=6: the
//      sweep takes 64 cycles.

Source files
------------

// File: rtl/regfile_nway.sv
// Parametrised N-way register bank: two combinational read ports, one write port,
// optional write-to-read bypass and a timed clear-all sweep.
module regfile_nway #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  din,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  dout_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  dout_b,
    input  logic              clr,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              busy_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic              wr_en_s;

    // A write is accepted only in IDLE and only when no clear is requested on the same edge.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == IDLE) && load && !clr) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage, sweep counter and the IDLE/CLEAR controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clr) begin
                        state_r <= CLEAR;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else if (wr_en_s) begin
                        mem_r[waddr] <= din;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    // load and clr are ignored here; the sweep always runs to completion.
                    mem_r[cnt_r] <= '0;
                    cnt_r        <= cnt_r + ADDR_W'(1);
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read port A: stored word, or din when bypassing an accepted write to the same address.
    always_comb begin
        dout_a = mem_r[raddr_a];
        if ((BYPASS != 0) && wr_en_s && (raddr_a == waddr)) begin
            dout_a = din;
        end else begin
            dout_a = mem_r[raddr_a];
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        dout_b = mem_r[raddr_b];
        if ((BYPASS != 0) && wr_en_s && (raddr_b == waddr)) begin
            dout_b = din;
        end else begin
            dout_b = mem_r[raddr_b];
        end
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_regfile_nway.sv
// Bench for regfile_nway: three instances (16x8 no bypass, 16x8 bypass, 8x64 no bypass)
// checked every cycle against an array model with a remaining-sweep-cycles counter.
module tb_regfile_nway;

    localparam int D1 = 8;
    localparam int D2 = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        ld = 1'b0, clr = 1'b0;
    logic [2:0]  wa = 3'd0, ra = 3'd0, rb = 3'd0;
    logic [15:0] din = 16'h0000;
    logic [15:0] d0a, d0b, d1a, d1b;
    logic        bz0, bz1;

    logic        ld2 = 1'b0, clr2 = 1'b0;
    logic [5:0]  wa2 = 6'd0, ra2 = 6'd0, rb2 = 6'd0;
    logic [7:0]  din2 = 8'h00;
    logic [7:0]  d2a, d2b;
    logic        bz2;

    logic [15:0] m1 [D1];
    logic [7:0]  m2 [D2];
    int          bl1, bl2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_nway #(.WIDTH(16), .ADDR_W(3), .BYPASS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .load(ld), .waddr(wa), .din(din),
        .raddr_a(ra), .dout_a(d0a), .raddr_b(rb), .dout_b(d0b), .clr(clr), .busy(bz0));

    regfile_nway #(.WIDTH(16), .ADDR_W(3), .BYPASS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load(ld), .waddr(wa), .din(din),
        .raddr_a(ra), .dout_a(d1a), .raddr_b(rb), .dout_b(d1b), .clr(clr), .busy(bz1));

    regfile_nway #(.WIDTH(8), .ADDR_W(6), .BYPASS(0)) u2 (
        .clk(clk), .rst_n(rst_n), .load(ld2), .waddr(wa2), .din(din2),
        .raddr_a(ra2), .dout_a(d2a), .raddr_b(rb2), .dout_b(d2b), .clr(clr2), .busy(bz2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D1; i++) m1[i] = 16'h0000;
        for (int i = 0; i < D2; i++) m2[i] = 8'h00;
        bl1 = 0;
        bl2 = 0;
    endtask

    task automatic check_all();
        logic        wr;
        logic [15:0] ea, eb;
        wr = (bl1 == 0) && ld && !clr;
        chk("u0_dout_a", d0a, m1[ra]);
        chk("u0_dout_b", d0b, m1[rb]);
        ea = (wr && ra == wa) ? din : m1[ra];
        eb = (wr && rb == wa) ? din : m1[rb];
        chk("u1_dout_a", d1a, ea);
        chk("u1_dout_b", d1b, eb);
        chk("u0_busy", {15'd0, bz0}, {15'd0, bl1 > 0});
        chk("u1_busy", {15'd0, bz1}, {15'd0, bl1 > 0});
        chk("u2_dout_a", {8'h00, d2a}, {8'h00, m2[ra2]});
        chk("u2_dout_b", {8'h00, d2b}, {8'h00, m2[rb2]});
        chk("u2_busy", {15'd0, bz2}, {15'd0, bl2 > 0});
    endtask

    // Clock edge as seen by the model: sweep one word, else start a sweep, else write.
    task automatic model_edge();
        if (bl1 > 0) begin
            m1[D1 - bl1] = 16'h0000;
            bl1--;
        end else if (clr) begin
            bl1 = D1;
        end else if (ld) begin
            m1[wa] = din;
        end
        if (bl2 > 0) begin
            m2[D2 - bl2] = 8'h00;
            bl2--;
        end else if (clr2) begin
            bl2 = D2;
        end else if (ld2) begin
            m2[wa2] = din2;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        ld = 1'b0; clr = 1'b0; ld2 = 1'b0; clr2 = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        ra = 3'd5; rb = 3'd2; ra2 = 6'd40; rb2 = 6'd1;
        #1 check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = 3'($urandom_range(7)); rb = 3'($urandom_range(7));
            ra2 = 6'($urandom_range(63)); rb2 = 6'($urandom_range(63));
            tick();
        end

        // 2. write and dual read, 3. bypass
        ra = 3'd3; rb = 3'd5; ra2 = 6'd3; rb2 = 6'd5;
        ld = 1'b1; wa = 3'd3; din = 16'h1234; ld2 = 1'b1; wa2 = 6'd3; din2 = 8'h34; tick();
        wa = 3'd5; din = 16'hFEDC; wa2 = 6'd5; din2 = 8'hDC; tick();
        idle_inputs(); tick();
        chk("read_a_1234", d0a, 16'h1234);
        chk("read_b_FEDC", d0b, 16'hFEDC);
        chk("u2_read_b_DC", {8'h00, d2b}, 16'h00DC);
        rb = 3'd3; tick();
        chk("same_addr_b", d0b, 16'h1234);
        ra = 3'd2; ld = 1'b1; wa = 3'd2; din = 16'hAAAA; #1;
        chk("bypass_same_cycle", d1a, 16'hAAAA);
        chk("nobypass_old", d0a, 16'h0000);
        tick();
        idle_inputs(); tick();

        // 4. clear sweep with dropped write during busy
        for (int i = 0; i < D1; i++) begin
            ld = 1'b1; wa = 3'(i); din = 16'h5555; tick();
        end
        for (int i = 0; i < D2; i++) begin
            ld2 = 1'b1; wa2 = 6'(i); din2 = 8'h55; tick();
        end
        idle_inputs();
        clr = 1'b1; clr2 = 1'b1; tick();
        clr = 1'b0; clr2 = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bz0) break;
            n++;
            ra = 3'(i % D1); rb = 3'((i + 3) % D1);
            ra2 = 6'($urandom_range(63)); rb2 = 6'(i % D2);
            ld = (i == 2); wa = 3'd0; din = 16'hFFFF;
            tick();
        end
        chk("busy_len_8", 16'(n), 16'd8);
        idle_inputs(); ra = 3'd0; #1;
        chk("word0_cleared", d0a, 16'h0000);
        n = 8;
        for (int i = 0; i < 200; i++) begin
            if (!bz2) break;
            n++;
            ra2 = 6'(i % D2); rb2 = 6'((i + 9) % D2);
            tick();
        end
        chk("busy_len_64", 16'(n), 16'd64);

        // 5. conflict, clr re-pulsed mid-sweep
        ld = 1'b1; wa = 3'd7; din = 16'h00FF; clr = 1'b1; tick();
        idle_inputs();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bz0) break;
            n++;
            clr = (i == 3); ra = 3'd7; rb = 3'(i % D1);
            tick();
        end
        idle_inputs();
        chk("busy_len_repulse", 16'(n), 16'd8);
        ra = 3'd7; #1;
        chk("conflict_word7", d0a, 16'h0000);

        // 6. reset mid-sweep
        for (int i = 0; i < D1; i++) begin
            ld = 1'b1; wa = 3'(i); din = 16'(16'hA000 + i); tick();
        end
        idle_inputs(); clr = 1'b1; clr2 = 1'b1; tick();
        idle_inputs();
        repeat (4) tick();
        rst_n = 1'b0; model_reset(); #1;
        chk("reset_busy0", {15'd0, bz0}, 16'd0);
        chk("reset_busy2", {15'd0, bz2}, 16'd0);
        for (int i = 0; i < D1; i++) begin
            ra = 3'(i); rb = 3'(D1 - 1 - i); ra2 = 6'(i * 7); #1;
            check_all();
        end
        rst_n = 1'b1; tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ld = 1'($urandom_range(1)); wa = 3'($urandom_range(7)); din = 16'($urandom);
            ra = 3'($urandom_range(7)); rb = 3'($urandom_range(7));
            clr = ($urandom_range(40) == 0);
            ld2 = 1'($urandom_range(1)); wa2 = 6'($urandom_range(63)); din2 = 8'($urandom);
            ra2 = ($urandom_range(1) == 1) ? wa2 : 6'($urandom_range(63));
            rb2 = 6'($urandom_range(63));
            clr2 = ($urandom_range(150) == 0);
            if ($urandom_range(3) == 0) ra = wa;
            tick();
        end
        idle_inputs(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
